// File: rtl/rx_serial_to_parallel.sv
// Serial-to-parallel RX front end. It hunts for the IDLE comma to find byte alignment,
// locks after BC_COUNT aligned commas, and then forwards non-IDLE bytes with a valid flag.
module rx_serial_to_parallel #(
   parameter logic [7:0]  IDLE     = 8'hBC,
   parameter int unsigned BC_COUNT = 4
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       strobe,
   output logic       active
);

   typedef enum logic [1:0] {SEARCH, COUNT, LOCKED} state_t;

   localparam logic [3:0] BC_MAX = 4'(BC_COUNT);

   state_t     state_q, state_d;
   logic [6:0] sr_q, sr_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [3:0] bc_cnt_q, bc_cnt_d;
   logic [7:0] data_out_q, data_out_d;
   logic       valid_q, valid_d;
   logic       strobe_q, strobe_d;
   logic       active_q, active_d;
   logic [7:0] cand;
   logic       boundary;

   // The candidate byte includes the bit being sampled, so a byte is visible on its LSB edge.
   assign cand     = {sr_q, data_in};
   assign boundary = (bit_cnt_q == 3'd7);

   always_comb begin
      state_d    = state_q;
      sr_d       = {sr_q[5:0], data_in};
      bit_cnt_d  = bit_cnt_q + 3'd1;
      bc_cnt_d   = bc_cnt_q;
      data_out_d = data_out_q;
      valid_d    = valid_q;
      strobe_d   = 1'b0;
      active_d   = active_q;
      case (state_q)
         SEARCH: begin
            bit_cnt_d = bit_cnt_q;
            if (cand == IDLE) begin
               bit_cnt_d = 3'd0;
               bc_cnt_d  = 4'd1;
               if (BC_MAX == 4'd1) begin
                  state_d  = LOCKED;
                  active_d = 1'b1;
               end else begin
                  state_d = COUNT;
               end
            end
         end
         COUNT: begin
            if (boundary) begin
               data_out_d = cand;
               strobe_d   = 1'b1;
               if (cand == IDLE) begin
                  bc_cnt_d = bc_cnt_q + 4'd1;
                  if (bc_cnt_q + 4'd1 == BC_MAX) begin
                     state_d  = LOCKED;
                     active_d = 1'b1;
                  end
               end else begin
                  bc_cnt_d = 4'd0;
                  state_d  = SEARCH;
               end
            end
         end
         LOCKED: begin
            if (boundary) begin
               data_out_d = cand;
               strobe_d   = 1'b1;
               valid_d    = (cand != IDLE);
            end
         end
         default: state_d = SEARCH;
      endcase
   end

   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         state_q    <= SEARCH;
         sr_q       <= '0;
         bit_cnt_q  <= '0;
         bc_cnt_q   <= '0;
         data_out_q <= '0;
         valid_q    <= 1'b0;
         strobe_q   <= 1'b0;
         active_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         bit_cnt_q  <= bit_cnt_d;
         bc_cnt_q   <= bc_cnt_d;
         data_out_q <= data_out_d;
         valid_q    <= valid_d;
         strobe_q   <= strobe_d;
         active_q   <= active_d;
      end
   end

   assign data_out  = data_out_q;
   assign valid_out = valid_q;
   assign strobe    = strobe_q;
   assign active    = active_q;

endmodule

// File: tb/tb_rx_serial_to_parallel.sv
// Directed bench for rx_serial_to_parallel: a BC_COUNT=4 instance and a BC_COUNT=1 instance
// share the serial line and reset.
module tb_rx_serial_to_parallel;

   logic       clk_32f = 1'b0;
   logic       reset   = 1'b0;
   logic       data_in = 1'b0;
   logic [7:0] data_out0, data_out1;
   logic       valid0, valid1, strobe0, strobe1, active0, active1;
   int         checks = 0;
   int         errors = 0;

   always #5 clk_32f = ~clk_32f;

   rx_serial_to_parallel #(.IDLE(8'hBC), .BC_COUNT(4)) dut0 (
      .clk_32f(clk_32f), .reset(reset), .data_in(data_in),
      .data_out(data_out0), .valid_out(valid0), .strobe(strobe0), .active(active0));

   rx_serial_to_parallel #(.IDLE(8'hBC), .BC_COUNT(1)) dut1 (
      .clk_32f(clk_32f), .reset(reset), .data_in(data_in),
      .data_out(data_out1), .valid_out(valid1), .strobe(strobe1), .active(active1));

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drives one bit at the falling edge, then returns 1 time unit after the sampling edge.
   task automatic send_bit(input logic b);
      @(negedge clk_32f) data_in = b;
      @(posedge clk_32f);
      #1;
   endtask

   task automatic send_msb7(input logic [7:0] b);
      for (int i = 7; i >= 1; i--) send_bit(b[i]);
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic chk0(input string tag, input logic [7:0] d, input logic v, input logic s,
                       input logic a);
      chk({tag, ".data"},   data_out0, d);
      chk({tag, ".valid"},  {7'd0, valid0}, {7'd0, v});
      chk({tag, ".strobe"}, {7'd0, strobe0}, {7'd0, s});
      chk({tag, ".active"}, {7'd0, active0}, {7'd0, a});
   endtask

   task automatic do_reset();
      @(negedge clk_32f) reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_32f) data_in = 1'($urandom_range(0, 1));
         #1;
         chk0("rst", 8'h00, 1'b0, 1'b0, 1'b0);
         chk("rst1.data", data_out1, 8'h00);
         chk("rst1.ctl", {5'd0, valid1, strobe1, active1}, 8'h00);
      end
      @(negedge clk_32f) begin
         data_in = 1'b0;
         reset   = 1'b1;
      end
   endtask

   initial begin
      // 1: reset held with random line activity
      do_reset();

      // 2: junk bits, four commas, then payload
      send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
      send_byte(8'hBC);
      chk0("t2.bc1", 8'h00, 1'b0, 1'b0, 1'b0);
      send_byte(8'hBC);
      chk0("t2.bc2", 8'hBC, 1'b0, 1'b1, 1'b0);
      send_byte(8'hBC);
      send_msb7(8'hBC);
      chk0("t2.bc4pre", 8'hBC, 1'b0, 1'b0, 1'b0);
      send_bit(1'b0);
      chk0("t2.bc4", 8'hBC, 1'b0, 1'b1, 1'b1);
      send_byte(8'h12);
      chk0("t2.b12", 8'h12, 1'b1, 1'b1, 1'b1);
      send_bit(1'b0);
      chk0("t2.hold1", 8'h12, 1'b1, 1'b0, 1'b1);
      for (int i = 6; i >= 1; i--) send_bit(1'(8'h34 >> i));
      chk0("t2.hold7", 8'h12, 1'b1, 1'b0, 1'b1);
      send_bit(1'b0);
      chk0("t2.b34", 8'h34, 1'b1, 1'b1, 1'b1);

      // 3: interrupted comma run, then a full run
      do_reset();
      send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hBC);
      send_byte(8'h55);
      chk0("t3.b55", 8'h55, 1'b0, 1'b1, 1'b0);
      send_byte(8'hBC);
      chk0("t3.bc1", 8'h55, 1'b0, 1'b0, 1'b0);
      send_byte(8'hBC); send_byte(8'hBC);
      chk0("t3.bc3", 8'hBC, 1'b0, 1'b1, 1'b0);
      send_byte(8'hBC);
      chk0("t3.bc4", 8'hBC, 1'b0, 1'b1, 1'b1);
      send_byte(8'hA7);
      chk0("t3.bA7", 8'hA7, 1'b1, 1'b1, 1'b1);

      // 4: IDLE inside locked payload
      send_byte(8'h01);
      chk0("t4.b01", 8'h01, 1'b1, 1'b1, 1'b1);
      send_byte(8'hBC);
      chk0("t4.bBC", 8'hBC, 1'b0, 1'b1, 1'b1);
      send_byte(8'h02);
      chk0("t4.b02", 8'h02, 1'b1, 1'b1, 1'b1);

      // 5: async reset mid-byte while locked
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      #2 reset = 1'b0;
      #1 chk0("t5.async", 8'h00, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk_32f);
      reset = 1'b1;
      send_byte(8'h11);
      chk0("t5.b11", 8'h00, 1'b0, 1'b0, 1'b0);
      send_byte(8'h22);
      chk0("t5.b22", 8'h00, 1'b0, 1'b0, 1'b0);
      send_byte(8'h33);
      send_byte(8'h44);
      chk0("t5.b44", 8'h00, 1'b0, 1'b0, 1'b0);
      send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hBC);
      chk0("t5.bc3", 8'hBC, 1'b0, 1'b1, 1'b0);
      send_byte(8'hBC);
      chk0("t5.bc4", 8'hBC, 1'b0, 1'b1, 1'b1);
      send_byte(8'h66);
      chk0("t5.b66", 8'h66, 1'b1, 1'b1, 1'b1);

      // 6: single-comma lock on the BC_COUNT=1 instance
      do_reset();
      send_byte(8'hBC);
      chk("t6.bc.active", {7'd0, active1}, 8'h01);
      chk("t6.bc.strobe", {7'd0, strobe1}, 8'h00);
      chk("t6.bc.data",   data_out1, 8'h00);
      chk("t6.bc.active0", {7'd0, active0}, 8'h00);
      send_byte(8'hF0);
      chk("t6.f0.data",   data_out1, 8'hF0);
      chk("t6.f0.valid",  {7'd0, valid1}, 8'h01);
      chk("t6.f0.strobe", {7'd0, strobe1}, 8'h01);
      send_bit(1'b0);
      chk("t6.f0.strobe_off", {7'd0, strobe1}, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
